gnn_example_weight: RTL and testbench
=====================================

# gnn_example_weight

Weight loader of the GNN accelerator kernel. On a one-cycle `ap_start` it decodes a 96-bit weight instruction and requests a DRAM transfer. It packs incoming 512-bit stream beats into 8192-bit weight-buffer lines and writes those lines to consecutive weight-buffer addresses. It pulses `ap_done` back to the controller when finished.

## Interface
- `WEIGHT_INST_LENGTH`, 96: instruction width.
- `C_M_AXI_ADDR_WIDTH`, 64: DRAM address width.
- `C_M_AXI_DATA_WIDTH`, 512: beat width (64 B).
- `C_XFER_SIZE_WIDTH`, 32: transfer-size width.
- `C_ADDER_BIT_WIDTH`, 32: reserved, unused.

Ports (direction, width, meaning):
- `kernel_clk` in 1: clock. All logic runs on this clock.
- `kernel_rst` in 1: **reset `kernel_rst`, asynchronous, active-high; clock `kernel_clk`.**
- `aclk`, `areset` in 1: reserved; unused.
- `m_axi_arvalid` out 1, `m_axi_arready` in 1, `m_axi_araddr` out 64, `m_axi_arlen` out 8: AXI read address channel.
- `m_axi_rvalid` in 1, `m_axi_rready` out 1, `m_axi_rdata` in 512, `m_axi_rlast` in 1: AXI read data channel.
- `ap_start` in 1: instruction valid pulse.
- `ap_done` out 1: completion pulse.
- `ctrl_addr_offset` in 64: DRAM base address.
- `ctrl_instruction` in 96: instruction word.
- `dram_xfer_start_addr` out 64, `dram_xfer_size_in_bytes` out 32: transfer descriptor.
- `read_start` out 1: transfer request pulse.
- `read_done` out 1: transfer complete pulse.
- `data_tvalid` in 1, `data_tready` out 1, `data_tlast` in 1, `data_tdata` in 512: beat stream. `data_tlast` is ignored.
- `weight_write_buffer_valid` out 1, `weight_write_buffer_addr` out 13, `weight_write_buffer_data` out 8192: buffer write port.

## Operation
Instruction fields:
- [95:80] DADDR: DRAM offset in 64-B units.
- [79:64] reserved.
- [63:48] NLINES: number of buffer lines.
- [47:32] BADDR: buffer start address; low 13 bits are used.
- [31:0] reserved.

Derived transfer values:
- `dram_xfer_start_addr` = `ctrl_addr_offset` + (DADDR<<6).
- `dram_xfer_size_in_bytes` = NLINES<<10. One line is 1024 B, i.e. 16 beats.

State machine:
- **IDLE:** `ap_start`=1 latches all fields and the derived values, then goes to REQ. If NLINES=0, goes directly to DONE.
- **REQ:** `read_start`=1 for exactly one cycle, then RECV.
- **RECV:** `data_tready`=1 every cycle; the source does not honour backpressure. Each accepted beat (`tvalid`&&`tready`) is stored at slice [k*512 +: 512], where k = beat index mod 16 (beat 0 is the LSBs). On the 16th beat, the line is copied to the output register and a write is issued at BADDR+line index, wrapping mod 8192. After NLINES*16 beats: `read_done` pulses once and the state goes to DONE.
- **DONE:** `ap_done`=1 for one cycle, then IDLE.

Other rules:
- `ap_start` outside IDLE is ignored.
- Beats arriving while not in RECV are dropped (`tready`=0).
- `dram_xfer_*` outputs hold until the next accepted instruction.

## Timing
- Reset value of every output is 0, including the `m_axi_*` outputs and the buffer outputs.
- `ap_start` accepted at edge T: `read_start` high in cycle T+1.
- Last beat of a line accepted at edge B: `weight_write_buffer_valid` is high for exactly the cycle after B, with address and data stable in that cycle.
- Final beat accepted at edge B: `read_done` high in cycle B+1, `ap_done` high in cycle B+2.
- Beats may arrive back-to-back. A line write and the first beat of the next line overlap with no stall.
- Reset asserted mid-transfer: return to IDLE, clear counters and outputs. A partial line is never written.

## Configuration
`WEIGHT_AXI_MASTER_EN` controls the stream source.
- **Defined:** the internal AXI read master fetches the transfer.
  - Bursts of 16 beats (`arlen`=15), one outstanding burst at a time.
  - Beats come from `m_axi_rdata` with `rready`=1 in RECV.
  - `data_*` inputs are ignored.
  - `read_done` fires after the last `rlast`.
- **Undefined:** `m_axi_arvalid`, `m_axi_araddr`, `m_axi_arlen` and `m_axi_rready` are tied to 0. Beats come from `data_*`, and `read_done` derives from the beat count.

## Structure
- Package `gnn_weight_pkg` holds:
  - field positions;
  - LINE_BEATS=16;
  - LINE_BYTES_LOG2=10;
  - BEAT_BYTES_LOG2=6;
  - BUF_ADDR_W=13;
  - the state enum.
- One sub-module, `gnn_weight_axi_read_master`, is instantiated only under `WEIGHT_AXI_MASTER_EN`.

## Test plan
- Instruction {1024,0,1,0,0,0}, offset 0 → `dram_xfer_start_addr`=65536, size=1024, one `read_start` pulse. 16 beats give one write at addr 0, data slice 0 = first beat, then `ap_done` 2 cycles after the last beat.
- Instruction {10240,0,10,12,0,0} with 160 back-to-back beats → size=10240, 10 writes at addrs 12..21 with no beat lost, exactly one `ap_done`.
- `ap_start` during RECV → ignored; the descriptor and the write count are unchanged.
- NLINES=0 → no `read_start`, `ap_done` 2 cycles after `ap_start`.
- BADDR=8190, NLINES=3 → writes at 8190, 8191, 0.
- `kernel_rst` after 8 beats → all outputs 0, no write issued, and the next instruction runs normally.

Source files
------------

// File: rtl/gnn_weight_pkg.sv
// gnn_weight_pkg: shared constants and types for the GNN weight loader.
//   - Instruction field positions (DADDR, NLINES, BADDR)
//   - Line/beat geometry (LINE_BEATS, LINE_BYTES_LOG2, BEAT_BYTES_LOG2)
//   - Weight-buffer address width (BUF_ADDR_W)
//   - Loader state enum
package gnn_weight_pkg;

  localparam int INST_W          = 96;
  localparam int DADDR_LSB       = 80;
  localparam int DADDR_W         = 16;
  localparam int NLINES_LSB      = 48;
  localparam int NLINES_W        = 16;
  localparam int BADDR_LSB       = 32;

  localparam int LINE_BEATS      = 16;
  localparam int LINE_BYTES_LOG2 = 10;
  localparam int BEAT_BYTES_LOG2 = 6;
  localparam int BUF_ADDR_W      = 13;

  localparam int BEAT_W          = 512;
  localparam int LINE_W          = LINE_BEATS * BEAT_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV,
    ST_DONE
  } wl_state_e;

endpackage

// File: rtl/gnn_example_weight_if.sv
// gnn_example_weight_if: 512-bit beat stream feeding the weight loader.
//   data_tvalid / data_tready : beat handshake (source does not honour tready)
//   data_tlast                : carried for completeness, ignored by the loader
//   data_tdata                : beat payload
// modport master = stream source, modport slave = loader side.
interface gnn_example_weight_if #(
  parameter int DATA_W = 512
);
  logic              data_tvalid;
  logic              data_tready;
  logic              data_tlast;
  logic [DATA_W-1:0] data_tdata;

  modport master (output data_tvalid, output data_tlast, output data_tdata, input data_tready);
  modport slave  (input data_tvalid, input data_tlast, input data_tdata, output data_tready);
endinterface

// File: rtl/gnn_weight_axi_read_master.sv
// gnn_weight_axi_read_master: fetches a weight transfer over AXI read.
//   go          : one-cycle request; base_addr / num_bursts sampled here
//   active      : loader is receiving; drives rready
//   m_axi_ar*   : address channel, 16-beat bursts, one outstanding at a time
//   m_axi_r*    : data channel
//   beat_fire   : beat accepted this cycle, payload on beat_data
//   final_beat  : accepted beat is the rlast of the final burst
module gnn_weight_axi_read_master
  import gnn_weight_pkg::*;
(
  input  logic              kernel_clk,
  input  logic              kernel_rst,
  input  logic              go,
  input  logic [63:0]       base_addr,
  input  logic [15:0]       num_bursts,
  input  logic              active,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [63:0]       m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [BEAT_W-1:0] m_axi_rdata,
  input  logic              m_axi_rlast,
  output logic              beat_fire,
  output logic [BEAT_W-1:0] beat_data,
  output logic              final_beat
);

  logic        busy;
  logic [15:0] burst_cnt;
  logic        last_burst;

  assign m_axi_rready = active;
  assign beat_fire    = m_axi_rvalid && active;
  assign beat_data    = m_axi_rdata;
  assign last_burst   = (burst_cnt == num_bursts - 16'd1);
  assign final_beat   = beat_fire && m_axi_rlast && busy && last_burst;

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      busy          <= 1'b0;
      burst_cnt     <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
    end else if (go) begin
      busy          <= 1'b1;
      burst_cnt     <= '0;
      m_axi_arvalid <= 1'b1;
      m_axi_araddr  <= base_addr;
      m_axi_arlen   <= 8'(LINE_BEATS - 1);
    end else if (busy) begin
      if (m_axi_arvalid && m_axi_arready)
        m_axi_arvalid <= 1'b0;
      // Next burst is only requested once the current one has fully returned.
      if (beat_fire && m_axi_rlast) begin
        if (last_burst) begin
          busy <= 1'b0;
        end else begin
          burst_cnt     <= burst_cnt + 16'd1;
          m_axi_araddr  <= m_axi_araddr + (64'd1 << LINE_BYTES_LOG2);
          m_axi_arvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gnn_example_weight.sv
// gnn_example_weight: weight loader of the GNN accelerator kernel.
// Decodes a weight instruction on ap_start, requests a DRAM transfer, packs
// 16 incoming 512-bit beats into each 8192-bit line and writes the lines to
// consecutive weight-buffer addresses, then pulses ap_done.
//
// Ports:
//   kernel_clk, kernel_rst (async, active-high)   aclk, areset: unused
//   m_axi_ar*/m_axi_r*     : AXI read master (only live with WEIGHT_AXI_MASTER_EN)
//   ap_start / ap_done     : instruction pulse / completion pulse
//   ctrl_addr_offset, ctrl_instruction : DRAM base and instruction word
//   dram_xfer_start_addr, dram_xfer_size_in_bytes, read_start, read_done
//   strm (slave)           : beat stream source in the default build
//   weight_write_buffer_*  : line write port
//
// Build option: WEIGHT_AXI_MASTER_EN selects the internal AXI read master as
// the beat source; otherwise beats come from strm and the AXI outputs are 0.
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | waiting for ap_start
// ST_REQ    | read_start pulse cycle
// ST_RECV   | accepting beats, writing completed lines
// ST_DONE   | issuing ap_done, back to idle
module gnn_example_weight
  import gnn_weight_pkg::*;
#(
  parameter int WEIGHT_INST_LENGTH = 96,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_ADDER_BIT_WIDTH  = 32
) (
  input  logic                          kernel_clk,
  input  logic                          kernel_rst,
  input  logic                          aclk,
  input  logic                          areset,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                          m_axi_rlast,
  input  logic                          ap_start,
  output logic                          ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [WEIGHT_INST_LENGTH-1:0] ctrl_instruction,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes,
  output logic                          read_start,
  output logic                          read_done,
  gnn_example_weight_if.slave           strm,
  output logic                          weight_write_buffer_valid,
  output logic [BUF_ADDR_W-1:0]         weight_write_buffer_addr,
  output logic [LINE_W-1:0]             weight_write_buffer_data
);

  wl_state_e             state;
  logic [NLINES_W-1:0]   nlines_q;
  logic [BUF_ADDR_W-1:0] baddr_q;
  logic [3:0]            beat_idx;
  logic [NLINES_W-1:0]   line_idx;
  logic [LINE_W-1:0]     line_q;

  logic                  recv_active;
  logic                  beat_fire;
  logic [BEAT_W-1:0]     beat_data;
  logic                  final_beat;

  logic [DADDR_W-1:0]    inst_daddr;
  logic [NLINES_W-1:0]   inst_nlines;

  assign inst_daddr  = ctrl_instruction[DADDR_LSB +: DADDR_W];
  assign inst_nlines = ctrl_instruction[NLINES_LSB +: NLINES_W];
  assign recv_active = (state == ST_RECV);

  logic unused_common;
  assign unused_common = &{1'b0, aclk, areset, ctrl_instruction[79:64],
                           ctrl_instruction[47:45], ctrl_instruction[31:0],
                           (C_ADDER_BIT_WIDTH != 0)};

`ifdef WEIGHT_AXI_MASTER_EN
  gnn_weight_axi_read_master u_axi_rd (
    .kernel_clk    (kernel_clk),
    .kernel_rst    (kernel_rst),
    .go            (read_start),
    .base_addr     (dram_xfer_start_addr),
    .num_bursts    (nlines_q),
    .active        (recv_active),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rlast   (m_axi_rlast),
    .beat_fire     (beat_fire),
    .beat_data     (beat_data),
    .final_beat    (final_beat)
  );

  assign strm.data_tready = 1'b0;

  logic unused_src;
  assign unused_src = &{1'b0, strm.data_tvalid, strm.data_tlast, strm.data_tdata,
                        line_idx[NLINES_W-1:BUF_ADDR_W]};
`else
  assign m_axi_arvalid = 1'b0;
  assign m_axi_araddr  = '0;
  assign m_axi_arlen   = '0;
  assign m_axi_rready  = 1'b0;

  assign strm.data_tready = recv_active;
  assign beat_fire        = strm.data_tvalid && recv_active;
  assign beat_data        = strm.data_tdata;
  assign final_beat       = beat_fire && (beat_idx == 4'(LINE_BEATS - 1)) &&
                            (line_idx == nlines_q - 16'd1);

  logic unused_src;
  assign unused_src = &{1'b0, m_axi_arready, m_axi_rvalid, m_axi_rdata,
                        m_axi_rlast, strm.data_tlast};
`endif

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      state                     <= ST_IDLE;
      nlines_q                  <= '0;
      baddr_q                   <= '0;
      beat_idx                  <= '0;
      line_idx                  <= '0;
      line_q                    <= '0;
      ap_done                   <= 1'b0;
      read_start                <= 1'b0;
      read_done                 <= 1'b0;
      dram_xfer_start_addr      <= '0;
      dram_xfer_size_in_bytes   <= '0;
      weight_write_buffer_valid <= 1'b0;
      weight_write_buffer_addr  <= '0;
      weight_write_buffer_data  <= '0;
    end else begin
      ap_done                   <= 1'b0;
      read_start                <= 1'b0;
      read_done                 <= 1'b0;
      weight_write_buffer_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (ap_start) begin
            nlines_q                <= inst_nlines;
            baddr_q                 <= ctrl_instruction[BADDR_LSB +: BUF_ADDR_W];
            dram_xfer_start_addr    <= ctrl_addr_offset +
                                       (C_M_AXI_ADDR_WIDTH'(inst_daddr) << BEAT_BYTES_LOG2);
            dram_xfer_size_in_bytes <= C_XFER_SIZE_WIDTH'(inst_nlines) << LINE_BYTES_LOG2;
            beat_idx                <= '0;
            line_idx                <= '0;
            if (inst_nlines == '0) begin
              state <= ST_DONE;
            end else begin
              state      <= ST_REQ;
              read_start <= 1'b1;
            end
          end
        end

        ST_REQ: state <= ST_RECV;

        ST_RECV: begin
          if (beat_fire) begin
            line_q[{beat_idx, 9'd0} +: BEAT_W] <= beat_data;
            beat_idx <= beat_idx + 4'd1;
            // The 16th beat goes straight to the output so the next line's
            // first beat can land in line_q in the very next cycle.
            if (beat_idx == 4'(LINE_BEATS - 1)) begin
              weight_write_buffer_valid <= 1'b1;
              weight_write_buffer_addr  <= baddr_q + line_idx[BUF_ADDR_W-1:0];
              weight_write_buffer_data  <= {beat_data, line_q[LINE_W-BEAT_W-1:0]};
              line_idx                  <= line_idx + 16'd1;
            end
            if (final_beat) begin
              read_done <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          ap_done <= 1'b1;
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gnn_example_weight.sv
// tb_gnn_example_weight: directed self-checking bench for gnn_example_weight
// in its default build (beats supplied on the stream interface).
module tb_gnn_example_weight;

  logic          kernel_clk = 1'b0;
  logic          kernel_rst = 1'b1;
  logic          aclk = 1'b0;
  logic          areset = 1'b0;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [63:0]   m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;
  logic [511:0]  m_axi_rdata = '0;
  logic          m_axi_rlast = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_done;
  logic [63:0]   ctrl_addr_offset = '0;
  logic [95:0]   ctrl_instruction = '0;
  logic [63:0]   dram_xfer_start_addr;
  logic [31:0]   dram_xfer_size_in_bytes;
  logic          read_start;
  logic          read_done;
  logic          weight_write_buffer_valid;
  logic [12:0]   weight_write_buffer_addr;
  logic [8191:0] weight_write_buffer_data;

  gnn_example_weight_if #(.DATA_W(512)) strm ();

  gnn_example_weight dut (
    .kernel_clk                (kernel_clk),
    .kernel_rst                (kernel_rst),
    .aclk                      (aclk),
    .areset                    (areset),
    .m_axi_arvalid             (m_axi_arvalid),
    .m_axi_arready             (m_axi_arready),
    .m_axi_araddr              (m_axi_araddr),
    .m_axi_arlen               (m_axi_arlen),
    .m_axi_rvalid              (m_axi_rvalid),
    .m_axi_rready              (m_axi_rready),
    .m_axi_rdata               (m_axi_rdata),
    .m_axi_rlast               (m_axi_rlast),
    .ap_start                  (ap_start),
    .ap_done                   (ap_done),
    .ctrl_addr_offset          (ctrl_addr_offset),
    .ctrl_instruction          (ctrl_instruction),
    .dram_xfer_start_addr      (dram_xfer_start_addr),
    .dram_xfer_size_in_bytes   (dram_xfer_size_in_bytes),
    .read_start                (read_start),
    .read_done                 (read_done),
    .strm                      (strm),
    .weight_write_buffer_valid (weight_write_buffer_valid),
    .weight_write_buffer_addr  (weight_write_buffer_addr),
    .weight_write_buffer_data  (weight_write_buffer_data)
  );

  always #5 kernel_clk = ~kernel_clk;

  int cyc = 0;
  always @(posedge kernel_clk) cyc <= cyc + 1;

  // Pulse and write monitor, sampled mid-cycle. A cycle stamp of N means the
  // cycle immediately following edge N.
  int          rs_cnt = 0, rd_cnt = 0, ad_cnt = 0;
  int          rs_cyc = -1, rd_cyc = -1, ad_cyc = -1;
  int          wr_addr_q[$];
  int          wr_cyc_q[$];
  logic [63:0] wr_s0_q[$];
  logic [63:0] wr_s15_q[$];

  always @(negedge kernel_clk) begin
    if (read_start) begin rs_cnt++; rs_cyc = cyc; end
    if (read_done)  begin rd_cnt++; rd_cyc = cyc; end
    if (ap_done)    begin ad_cnt++; ad_cyc = cyc; end
    if (weight_write_buffer_valid) begin
      wr_addr_q.push_back(int'(weight_write_buffer_addr));
      wr_cyc_q.push_back(cyc);
      wr_s0_q.push_back(weight_write_buffer_data[63:0]);
      wr_s15_q.push_back(weight_write_buffer_data[15*512 +: 64]);
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [95:0] mk_inst(input logic [15:0] daddr, input logic [15:0] nlines,
                                          input logic [15:0] baddr);
    return {daddr, 16'h0, nlines, baddr, 32'h0};
  endfunction

  // Beat n carries the 32-bit word 0x1000_0000+n replicated across all 16 words.
  function automatic logic [511:0] beat_val(input int n);
    logic [31:0] w;
    w = 32'h1000_0000 + 32'(n);
    return {16{w}};
  endfunction

  function automatic logic [63:0] slice_val(input int n);
    logic [31:0] w;
    w = 32'h1000_0000 + 32'(n);
    return {w, w};
  endfunction

  int g = 0;

  task automatic issue(input logic [95:0] inst, output int t);
    ctrl_instruction = inst;
    ap_start = 1'b1;
    @(posedge kernel_clk); #1;
    ap_start = 1'b0;
    t = cyc;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!strm.data_tready && n < 20) begin
      @(posedge kernel_clk); #1;
      n++;
    end
    chk("tready_wait", 64'(strm.data_tready), 64'd1);
  endtask

  task automatic send(input int nbeats, output int last_cyc);
    for (int i = 0; i < nbeats; i++) begin
      strm.data_tvalid = 1'b1;
      strm.data_tdata  = beat_val(g);
      @(posedge kernel_clk); #1;
      g++;
    end
    strm.data_tvalid = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge kernel_clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_ap_done"},    64'(ap_done), 64'd0);
    chk({pfx, "_read_start"}, 64'(read_start), 64'd0);
    chk({pfx, "_read_done"},  64'(read_done), 64'd0);
    chk({pfx, "_wb_valid"},   64'(weight_write_buffer_valid), 64'd0);
    chk({pfx, "_wb_addr"},    64'(weight_write_buffer_addr), 64'd0);
    chk({pfx, "_wb_data"},    64'(|weight_write_buffer_data), 64'd0);
    chk({pfx, "_xfer_addr"},  dram_xfer_start_addr, 64'd0);
    chk({pfx, "_xfer_size"},  64'(dram_xfer_size_in_bytes), 64'd0);
    chk({pfx, "_tready"},     64'(strm.data_tready), 64'd0);
    chk({pfx, "_arvalid"},    64'(m_axi_arvalid), 64'd0);
    chk({pfx, "_araddr"},     m_axi_araddr, 64'd0);
    chk({pfx, "_arlen"},      64'(m_axi_arlen), 64'd0);
    chk({pfx, "_rready"},     64'(m_axi_rready), 64'd0);
  endtask

  initial begin
    int t, b, n0, rs0, ad0, g0, dummy;

    strm.data_tvalid = 1'b0;
    strm.data_tlast  = 1'b0;
    strm.data_tdata  = '0;

    idle(3);
    kernel_rst = 1'b0;
    idle(1);
    chk_outputs_zero("rst");

    // Single line, offset 0.
    n0 = wr_addr_q.size(); rs0 = rs_cnt; ad0 = ad_cnt;
    issue(mk_inst(16'd1024, 16'd1, 16'd0), t);
    chk("t1_xfer_addr", dram_xfer_start_addr, 64'd65536);
    chk("t1_xfer_size", 64'(dram_xfer_size_in_bytes), 64'd1024);
    wait_ready();
    chk("t1_rs_cyc", 64'(rs_cyc), 64'(t));
    g0 = g;
    send(16, b);
    idle(4);
    chk("t1_rs_cnt", 64'(rs_cnt - rs0), 64'd1);
    chk("t1_wr_cnt", 64'(wr_addr_q.size() - n0), 64'd1);
    if (wr_addr_q.size() > n0) begin
      chk("t1_wr_addr", 64'(wr_addr_q[n0]), 64'd0);
      chk("t1_wr_cyc",  64'(wr_cyc_q[n0]), 64'(b));
      chk("t1_s0",      wr_s0_q[n0], slice_val(g0));
      chk("t1_s15",     wr_s15_q[n0], slice_val(g0 + 15));
    end
    chk("t1_rd_cyc", 64'(rd_cyc), 64'(b));
    chk("t1_ad_cyc", 64'(ad_cyc), 64'(b + 1));
    chk("t1_ad_cnt", 64'(ad_cnt - ad0), 64'd1);

    // Ten lines back-to-back, with a stray ap_start during RECV.
    n0 = wr_addr_q.size(); rs0 = rs_cnt; ad0 = ad_cnt;
    issue(mk_inst(16'd10240, 16'd10, 16'd12), t);
    wait_ready();
    g0 = g;
    send(50, dummy);
    ctrl_instruction = mk_inst(16'd7, 16'd2, 16'd100);
    ap_start = 1'b1;
    send(1, dummy);
    ap_start = 1'b0;
    send(109, b);
    idle(4);
    chk("t2_xfer_addr", dram_xfer_start_addr, 64'd655360);
    chk("t2_xfer_size", 64'(dram_xfer_size_in_bytes), 64'd10240);
    chk("t2_rs_cnt", 64'(rs_cnt - rs0), 64'd1);
    chk("t2_wr_cnt", 64'(wr_addr_q.size() - n0), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (wr_addr_q.size() > n0 + i) begin
        chk($sformatf("t2_wr_addr%0d", i), 64'(wr_addr_q[n0 + i]), 64'(12 + i));
        chk($sformatf("t2_s0_%0d", i), wr_s0_q[n0 + i], slice_val(g0 + 16 * i));
        chk($sformatf("t2_s15_%0d", i), wr_s15_q[n0 + i], slice_val(g0 + 16 * i + 15));
      end
    end
    chk("t2_rd_cyc", 64'(rd_cyc), 64'(b));
    chk("t2_ad_cyc", 64'(ad_cyc), 64'(b + 1));
    chk("t2_ad_cnt", 64'(ad_cnt - ad0), 64'd1);

    // NLINES = 0: no transfer, ap_done two cycles after ap_start.
    rs0 = rs_cnt; ad0 = ad_cnt;
    issue(mk_inst(16'd5, 16'd0, 16'd3), t);
    idle(4);
    chk("t3_rs_cnt", 64'(rs_cnt - rs0), 64'd0);
    chk("t3_ad_cnt", 64'(ad_cnt - ad0), 64'd1);
    chk("t3_ad_cyc", 64'(ad_cyc), 64'(t + 1));
    chk("t3_xfer_size", 64'(dram_xfer_size_in_bytes), 64'd0);

    // Buffer address wraps past 8191; non-zero DRAM offset.
    n0 = wr_addr_q.size();
    ctrl_addr_offset = 64'h1_0000_0000;
    issue(mk_inst(16'd3, 16'd3, 16'd8190), t);
    chk("t4_xfer_addr", dram_xfer_start_addr, 64'h1_0000_00C0);
    chk("t4_xfer_size", 64'(dram_xfer_size_in_bytes), 64'd3072);
    wait_ready();
    send(48, b);
    idle(4);
    chk("t4_wr_cnt", 64'(wr_addr_q.size() - n0), 64'd3);
    if (wr_addr_q.size() >= n0 + 3) begin
      chk("t4_wr_addr0", 64'(wr_addr_q[n0]), 64'd8190);
      chk("t4_wr_addr1", 64'(wr_addr_q[n0 + 1]), 64'd8191);
      chk("t4_wr_addr2", 64'(wr_addr_q[n0 + 2]), 64'd0);
    end
    ctrl_addr_offset = '0;

    // Reset in the middle of a line, then a clean run.
    n0 = wr_addr_q.size();
    issue(mk_inst(16'd5, 16'd1, 16'd40), t);
    wait_ready();
    send(8, dummy);
    kernel_rst = 1'b1;
    #2;
    chk_outputs_zero("mid_rst");
    idle(2);
    kernel_rst = 1'b0;
    idle(3);
    chk("t5_wr_cnt_rst", 64'(wr_addr_q.size() - n0), 64'd0);
    chk("t5_state_idle", 64'(strm.data_tready), 64'd0);

    ad0 = ad_cnt;
    issue(mk_inst(16'd2, 16'd1, 16'd7), t);
    chk("t5_xfer_addr", dram_xfer_start_addr, 64'd128);
    wait_ready();
    g0 = g;
    send(16, b);
    idle(4);
    chk("t5_wr_cnt", 64'(wr_addr_q.size() - n0), 64'd1);
    if (wr_addr_q.size() > n0) begin
      chk("t5_wr_addr", 64'(wr_addr_q[n0]), 64'd7);
      chk("t5_s0",      wr_s0_q[n0], slice_val(g0));
      chk("t5_s15",     wr_s15_q[n0], slice_val(g0 + 15));
    end
    chk("t5_ad_cyc", 64'(ad_cyc), 64'(b + 1));
    chk("t5_ad_cnt", 64'(ad_cnt - ad0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
